// File: rtl/ecc_pkg.sv
// ecc_pkg: state encoding and default sizes for the ECC scalar-multiply controller
package ecc_pkg;
  localparam int N_DEF = 231;
  localparam int KW_DEF = 231;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [3:0] {IDLE, SCAN, DBL_GO, DBL_WAIT, BIT, ADD_GO, ADD_WAIT, NEXT, FIN} state_e;
endpackage

// File: rtl/ecc_unit_launcher.sv
// ecc_unit_launcher: launch strobe and result watchdog for one external point unit
module ecc_unit_launcher
  import ecc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic wt,
  input  logic result,
  input  logic infinity,
  output logic unit_reset,
  output logic ok,
  output logic inf,
  output logic timeout
);
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  // The unit is held in reset everywhere except its wait state, so the strobe falls on launch
  always_comb begin
    wdog_d = wt ? wdog_q + 1'b1 : '0;
    unit_reset = !wt;
    inf = wt && infinity;
    ok = wt && result && !infinity;
    timeout = wt && !result && !infinity && wdog_q == WW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) wdog_q <= '0;
    else wdog_q <= wdog_d;
endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// ecc_scalar_mult_ctrl: left-to-right double-and-add sequencer for Q = k*P,
// driving external point doubling/addition units and tracking the infinity accumulator
module ecc_scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int KW = KW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [N-1:0]  px,
  input  logic [N-1:0]  py,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  qx,
  output logic [N-1:0]  qy,
  output logic          q_inf,
  output logic          err,
  output logic          dbl_reset,
  output logic [N-1:0]  dbl_x1,
  output logic [N-1:0]  dbl_y1,
  input  logic [N-1:0]  dbl_x3,
  input  logic [N-1:0]  dbl_y3,
  input  logic          dbl_result,
  input  logic          dbl_infinity,
  output logic          add_reset,
  output logic [N-1:0]  add_x1,
  output logic [N-1:0]  add_y1,
  output logic [N-1:0]  add_x2,
  output logic [N-1:0]  add_y2,
  input  logic [N-1:0]  add_x3,
  input  logic [N-1:0]  add_y3,
  input  logic          add_result,
  input  logic          add_infinity
);
  localparam int IW = $clog2(KW);
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0] px_q, px_d, py_q, py_d, ax_q, ax_d, ay_q, ay_d, qx_q, qx_d, qy_q, qy_d;
  logic ainf_q, ainf_d, q_inf_q, q_inf_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic dbl_ok, dbl_inf, dbl_to, add_ok, add_inf, add_to;
  ecc_unit_launcher #(.TIMEOUT(TIMEOUT)) u_dbl (
    .clk(clk), .reset(reset), .wt(state_q == DBL_WAIT), .result(dbl_result),
    .infinity(dbl_infinity), .unit_reset(dbl_reset), .ok(dbl_ok), .inf(dbl_inf), .timeout(dbl_to)
  );
  ecc_unit_launcher #(.TIMEOUT(TIMEOUT)) u_add (
    .clk(clk), .reset(reset), .wt(state_q == ADD_WAIT), .result(add_result),
    .infinity(add_infinity), .unit_reset(add_reset), .ok(add_ok), .inf(add_inf), .timeout(add_to)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign qx = qx_q;
  assign qy = qy_q;
  assign q_inf = q_inf_q;
  assign err = err_q;
  assign dbl_x1 = ax_q;
  assign dbl_y1 = ay_q;
  assign add_x1 = ax_q;
  assign add_y1 = ay_q;
  assign add_x2 = px_q;
  assign add_y2 = py_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    px_d = px_q;
    py_d = py_q;
    ax_d = ax_q;
    ay_d = ay_q;
    ainf_d = ainf_q;
    idx_d = idx_q;
    qx_d = qx_q;
    qy_d = qy_q;
    q_inf_d = q_inf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        k_d = k;
        px_d = px;
        py_d = py;
        ainf_d = 1'b1;
        idx_d = IW'(KW - 1);
        busy_d = 1'b1;
        err_d = 1'b0;
        state_d = SCAN;
      end
      // Leading zero bits cost one cycle each; the first set bit just loads P
      SCAN: if (k_q[idx_q]) begin
        ax_d = px_q;
        ay_d = py_q;
        ainf_d = 1'b0;
        state_d = NEXT;
      end else if (idx_q == '0) state_d = FIN;
      else idx_d = idx_q - 1'b1;
      DBL_GO: state_d = DBL_WAIT;
      DBL_WAIT: if (dbl_inf) begin
        ainf_d = 1'b1;
        state_d = BIT;
      end else if (dbl_ok) begin
        ax_d = dbl_x3;
        ay_d = dbl_y3;
        state_d = BIT;
      end else if (dbl_to) begin
        err_d = 1'b1;
        state_d = FIN;
      end
      BIT: if (!k_q[idx_q]) state_d = NEXT;
      else if (ainf_q) begin
        ax_d = px_q;
        ay_d = py_q;
        ainf_d = 1'b0;
        state_d = NEXT;
      end else state_d = ADD_GO;
      ADD_GO: state_d = ADD_WAIT;
      ADD_WAIT: if (add_inf) begin
        ainf_d = 1'b1;
        state_d = NEXT;
      end else if (add_ok) begin
        ax_d = add_x3;
        ay_d = add_y3;
        state_d = NEXT;
      end else if (add_to) begin
        err_d = 1'b1;
        state_d = FIN;
      end
      NEXT: if (idx_q == '0) state_d = FIN;
      else begin
        idx_d = idx_q - 1'b1;
        state_d = DBL_GO;
      end
      FIN: begin
        qx_d = ainf_q ? '0 : ax_q;
        qy_d = ainf_q ? '0 : ay_q;
        q_inf_d = ainf_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      px_q <= '0;
      py_q <= '0;
      ax_q <= '0;
      ay_q <= '0;
      ainf_q <= 1'b1;
      idx_q <= '0;
      qx_q <= '0;
      qy_q <= '0;
      q_inf_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      px_q <= px_d;
      py_q <= py_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      ainf_q <= ainf_d;
      idx_q <= idx_d;
      qx_q <= qx_d;
      qy_q <= qy_d;
      q_inf_q <= q_inf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// tb_ecc_scalar_mult_ctrl: scalar multiplication on y^2 = x^3 + 2x + 2 mod 17 with
// behavioural doubling/addition units and a scoreboard of expected results
module tb_ecc_scalar_mult_ctrl;
  localparam int N = 231, KW = 231, TIMEOUT = 4096, BOUND = 10000;
  typedef struct {int x; int y; bit inf;} pt_t;
  typedef struct {string name; int x; int y; bit inf; bit err; string ops;} exp_t;
  logic clk = 1'b0, reset, start;
  logic [KW-1:0] k;
  logic [N-1:0] px, py, qx, qy, dbl_x1, dbl_y1, dbl_x3, dbl_y3;
  logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;
  logic busy, done, q_inf, err, dbl_reset, add_reset;
  logic dbl_result = 1'b0, dbl_infinity = 1'b0, add_result = 1'b0, add_infinity = 1'b0;
  logic dprev, aprev;
  int checks = 0, failures = 0;
  int dlat = 3, alat = 4, dcnt = 0, acnt = 0, low_cnt = 0;
  bit dbl_hang = 0;
  string ops_log = "";
  pt_t dres, ares;
  exp_t sb[$];

  ecc_scalar_mult_ctrl #(.N(N), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf), .err(err),
    .dbl_reset(dbl_reset), .dbl_x1(dbl_x1), .dbl_y1(dbl_y1), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3),
    .dbl_result(dbl_result), .dbl_infinity(dbl_infinity),
    .add_reset(add_reset), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2), .add_y2(add_y2),
    .add_x3(add_x3), .add_y3(add_y3), .add_result(add_result), .add_infinity(add_infinity)
  );

  always #5 clk = ~clk;

  function automatic int md(int a);
    return ((a % 17) + 17) % 17;
  endfunction
  function automatic int inv(int a);
    int r = 1;
    for (int i = 0; i < 15; i++) r = md(r * md(a));
    return r;
  endfunction
  function automatic pt_t padd(pt_t a, pt_t b);
    pt_t r;
    int l;
    if (a.inf) return b;
    if (b.inf) return a;
    r = '{0, 0, 1'b1};
    if (a.x == b.x && md(a.y + b.y) == 0) return r;
    if (a.x == b.x) l = md((3 * a.x * a.x + 2) * inv(2 * a.y));
    else l = md((b.y - a.y) * inv(b.x - a.x));
    r.x = md(l * l - a.x - b.x);
    r.y = md(l * (a.x - r.x) - a.y);
    r.inf = 1'b0;
    return r;
  endfunction
  function automatic pt_t mk(logic [N-1:0] x, logic [N-1:0] y);
    pt_t r;
    r.x = int'(x);
    r.y = int'(y);
    r.inf = 1'b0;
    return r;
  endfunction
  function automatic pt_t smul(int kv);
    pt_t p = '{5, 1, 1'b0};
    pt_t r = '{0, 0, 1'b1};
    for (int i = 0; i < kv; i++) r = padd(r, p);
    return r;
  endfunction

  always_comb begin
    dres = padd(mk(dbl_x1, dbl_y1), mk(dbl_x1, dbl_y1));
    ares = padd(mk(add_x1, add_y1), mk(add_x2, add_y2));
  end

  // Behavioural units: computation starts once the launch strobe falls
  always @(posedge clk) begin
    dprev <= dbl_reset;
    aprev <= add_reset;
    if (dprev === 1'b1 && dbl_reset === 1'b0) ops_log <= {ops_log, "D"};
    else if (aprev === 1'b1 && add_reset === 1'b0) ops_log <= {ops_log, "A"};
    if (dbl_reset === 1'b0) low_cnt <= low_cnt + 1;
    dcnt <= dbl_reset ? 0 : dcnt + 1;
    acnt <= add_reset ? 0 : acnt + 1;
    dbl_result <= !dbl_reset && !dbl_hang && dcnt == dlat && !dres.inf;
    dbl_infinity <= !dbl_reset && (dbl_infinity || (!dbl_hang && dcnt == dlat && dres.inf));
    add_result <= !add_reset && acnt == alat && !ares.inf;
    add_infinity <= !add_reset && (add_infinity || (acnt == alat && ares.inf));
    if (!dbl_reset && dcnt == dlat) begin
      dbl_x3 <= N'(dres.x);
      dbl_y3 <= N'(dres.y);
    end
    if (!add_reset && acnt == alat) begin
      add_x3 <= N'(ares.x);
      add_y3 <= N'(ares.y);
    end
  end

  task automatic run_op(input string name, input int kv, input string eops, input bit eerr,
                        input bit inject, output int cyc);
    exp_t e;
    pt_t r;
    int ops0;
    r = smul(kv);
    e.name = name;
    e.x = r.inf ? 0 : r.x;
    e.y = r.inf ? 0 : r.y;
    e.inf = r.inf;
    e.err = eerr;
    e.ops = eops;
    sb.push_back(e);
    ops0 = ops_log.len();
    @(negedge clk);
    k = KW'(kv);
    px = N'(5);
    py = N'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < BOUND) begin
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
      end
      start = inject && cyc == 6;
      if (inject && cyc == 6) begin
        k = KW'(2);
        px = N'(9);
        py = N'(16);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    px = N'(5);
    py = N'(1);
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s done_wait: no done within %0d cycles", name, BOUND);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (err !== e.err) begin failures++; $display("FAIL %s err: got %b want %b", e.name, err, e.err); end
    checks++;
    if (ops_log.substr(ops0, ops_log.len() - 1) != e.ops) begin
      failures++;
      $display("FAIL %s launch_order: got '%s' want '%s'", e.name, ops_log.substr(ops0, ops_log.len() - 1), e.ops);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b want 0", e.name, busy); end
    if (!e.err) begin
      checks++;
      if (qx !== N'(e.x)) begin failures++; $display("FAIL %s qx: got %0d want %0d", e.name, qx, e.x); end
      checks++;
      if (qy !== N'(e.y)) begin failures++; $display("FAIL %s qy: got %0d want %0d", e.name, qy, e.y); end
      checks++;
      if (q_inf !== e.inf) begin failures++; $display("FAIL %s q_inf: got %b want %b", e.name, q_inf, e.inf); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL %s done_width: got %b want 0", e.name, done); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    k = '0;
    px = N'(5);
    py = N'(1);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b want 0", done); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset err: got %b want 0", err); end
    checks++;
    if (q_inf !== 1'b1) begin failures++; $display("FAIL reset q_inf: got %b want 1", q_inf); end
    checks++;
    if (qx !== '0 || qy !== '0) begin failures++; $display("FAIL reset q: got (%0d,%0d) want (0,0)", qx, qy); end
    checks++;
    if (dbl_reset !== 1'b1 || add_reset !== 1'b1) begin
      failures++;
      $display("FAIL reset strobes: got dbl=%b add=%b want 1 1", dbl_reset, add_reset);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_k_zero();
    int cyc;
    run_op("k0", 0, "", 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != KW + 2) begin failures++; $display("FAIL k0 latency: got %0d want %0d", cyc, KW + 2); end
  endtask

  task automatic test_scalars();
    int cyc;
    run_op("k1", 1, "", 1'b0, 1'b0, cyc);
    run_op("k2", 2, "D", 1'b0, 1'b0, cyc);
    run_op("k7", 7, "DADA", 1'b0, 1'b0, cyc);
    run_op("k19", 19, "DDDADA", 1'b0, 1'b0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int dn = 0;
    run_op("busy_start", 7, "DADA", 1'b0, 1'b1, cyc);
    repeat (KW + 30) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL busy_start extra_done: got %0d want 0", dn); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_timeout();
    int cyc;
    int lc0;
    dbl_hang = 1'b1;
    lc0 = low_cnt;
    run_op("timeout", 2, "D", 1'b1, 1'b0, cyc);
    checks++;
    if (low_cnt - lc0 != TIMEOUT) begin
      failures++;
      $display("FAIL timeout wait_cycles: got %0d want %0d", low_cnt - lc0, TIMEOUT);
    end
    dbl_hang = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    int dn = 0;
    dlat = 40;
    @(negedge clk);
    k = KW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (dbl_reset !== 1'b0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbl_reset !== 1'b0) begin failures++; $display("FAIL midreset reach_wait: got dbl_reset=%b want 0", dbl_reset); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b want 0", busy); end
    checks++;
    if (q_inf !== 1'b1 || qx !== '0 || qy !== '0) begin
      failures++;
      $display("FAIL midreset q: got (%0d,%0d,%b) want (0,0,1)", qx, qy, q_inf);
    end
    checks++;
    if (dbl_reset !== 1'b1 || add_reset !== 1'b1) begin
      failures++;
      $display("FAIL midreset strobes: got dbl=%b add=%b want 1 1", dbl_reset, add_reset);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midreset done_err: got %b %b want 0 0", done, err); end
    @(negedge clk);
    reset = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL midreset done_after: got %0d want 0", dn); end
    dlat = 3;
  endtask

  initial begin
    test_reset();
    test_k_zero();
    test_scalars();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
Initiator/sequencer for ECC scalar multiplication Q = k·P over GF(p), using left-to-right double-and-add.
Does no field arithmetic itself. It drives an external point-doubling unit and an external point-addition unit through their reset-launch / result-pulse handshake, and tracks the point-at-infinity accumulator.
Sits between the top-level crypto wrapper and the point_doubling / point_addition datapaths.

Parameters:
N, 231, field/coordinate width in bits.
KW, 231, scalar width in bits.
TIMEOUT, 4096, maximum cycles to wait for a unit result pulse before aborting.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
k  input  KW  scalar; captured on accepted start
px  input  N  base point x; captured on accepted start
py  input  N  base point y; captured on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the result is valid
qx  output  N  result x; held until next accepted start
qy  output  N  result y; held until next accepted start
q_inf  output  1  result is the point at infinity
err  output  1  a unit timed out; valid with done
dbl_reset  output  1  launch strobe to the doubling unit; high 1 cycle, doubling computes after it falls
dbl_x1  output  N  doubling operand x, held stable while waiting
dbl_y1  output  N  doubling operand y, held stable while waiting
dbl_x3  input  N  doubling result x
dbl_y3  input  N  doubling result y
dbl_result  input  1  doubling result pulse
dbl_infinity  input  1  doubling result is infinity (level; checked from the cycle after launch)
add_reset  output  1  launch strobe to the addition unit
add_x1  output  N  addition operand 1 x (accumulator Q)
add_y1  output  N  addition operand 1 y
add_x2  output  N  addition operand 2 x (base P)
add_y2  output  N  addition operand 2 y
add_x3  input  N  addition result x
add_y3  input  N  addition result y
add_result  input  1  addition result pulse
add_infinity  input  1  addition result is infinity

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, q_inf=1, qx=0, qy=0.
  - dbl_reset=1 and add_reset=1, so both units are held idle.
  - FSM in IDLE; bit index and watchdog are 0.
- Registers: Kreg, Preg, accumulator (QX, QY, QINF), idx[$clog2(KW)-1:0], wdog counter.
- States:
  - IDLE: on start, capture k/px/py, set QINF=1, idx=KW-1, busy=1, go to SCAN.
  - SCAN (one bit per cycle):
    - If Kreg[idx]=1: QX=px, QY=py, QINF=0, go to NEXT. The first set bit needs no arithmetic.
    - If Kreg[idx]=0 and idx=0: k=0, go to FIN with QINF=1.
    - Otherwise idx--.
  - DBL_GO: dbl_reset=1 for exactly one cycle with dbl_x1/y1=QX/QY. Clear wdog. Go to DBL_WAIT.
  - DBL_WAIT: dbl_reset=0.
    - If dbl_infinity=1: QINF=1, go to BIT.
    - Else on dbl_result: QX/QY=dbl_x3/y3, go to BIT.
    - If wdog reaches TIMEOUT: err=1, go to FIN.
  - BIT:
    - If Kreg[idx]=0: go to NEXT.
    - If Kreg[idx]=1 and QINF=1: QX/QY=Preg, QINF=0, go to NEXT.
    - Otherwise go to ADD_GO.
  - ADD_GO / ADD_WAIT: same handshake and watchdog as the doubling pair.
    - add_infinity sets QINF=1.
    - add_result loads QX/QY from add_x3/y3.
    - Then go to NEXT.
  - NEXT: if idx=0 go to FIN; else idx--, go to DBL_GO.
  - FIN: qx/qy/q_inf take the accumulator (qx=qy=0 when QINF). done=1 for one cycle, busy=0. Go to IDLE.
- Latency:
  - k=0: KW+2 cycles from start to done.
  - Otherwise: SCAN cycles + Σ(unit latencies + 3 per doubling, +3 per addition) + 1.
- start while busy is ignored; there is no queueing.
- If the unit result pulse and the watchdog expiry occur in the same cycle, the result wins.
- Unit strobes idle high outside GO/WAIT states. Launched units are therefore held in reset between operations.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced.
- All scalars are treated as unsigned. Coordinates are assumed already reduced mod p. The controller never compares or reduces them.

Decomposition:
- Package ecc_pkg holds:
  - the FSM state enum (IDLE, SCAN, DBL_GO, DBL_WAIT, BIT, ADD_GO, ADD_WAIT, NEXT, FIN);
  - default N/KW/TIMEOUT localparams.
- One sub-module, ecc_unit_launcher, instantiated twice. It generates the one-cycle strobe, runs the watchdog, and emits ok/inf/timeout.

Test Plan:
- k=0, P=(5,1) -> done after KW+2 cycles, q_inf=1, qx=qy=0, no strobe ever falls.
- k=1, P=(5,1) -> no unit launch; done with qx=5, qy=1, q_inf=0.
- k=2 on y²=x³+2x+2 mod 17, P=(5,1), behavioural units -> one doubling, zero additions; result (6,3).
- k=19 (order) on the same curve -> ends with add_infinity; q_inf=1, err=0.
- k=7 on the same curve -> double, add, double, add sequence in strobe order; result (0,6).
- Doubling model that never pulses result -> err=1 and done after TIMEOUT wait cycles.
- Async reset asserted mid-DBL_WAIT -> outputs return to reset values immediately.
- start pulsed while busy -> ignored; the original result completes unchanged.
